apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between NREQ local requesters.
- Round-robin arbiter plus APB master FSM (IDLE/SETUP/ACCESS) with a PREADY timeout.
- Sits between the requester-side logic and the APB slave inside the APB top level, replacing the single read_or_write command input.
- Returns read data and error status to the requester that issued each transfer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, APB address width.
- DW, 8, APB data width.
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (≥2).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NREQ  per-requester transfer request, held until granted.
- req_write_i  in  NREQ  1=write, 0=read.
- req_addr_i  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- req_wdata_i  in  NREQ*DW  flattened write data.
- req_ready_o  out  NREQ  one-hot, 1-cycle pulse: request accepted.
- rsp_valid_o  out  NREQ  one-hot, 1-cycle pulse: transfer done.
- rsp_rdata_o  out  DW  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  PSLVERR or timeout, valid with rsp_valid_o.
- PADDR_o  out  AW  APB address.
- PWDATA_o  out  DW  APB write data.
- PWRITE_o  out  1  APB direction.
- PSEL_o  out  1  APB select.
- PENABLE_o  out  1  APB enable.
- PRDATA_i  in  DW  APB read data.
- PREADY_i  in  1  APB ready.
- PSLVERR_i  in  1  APB slave error.

Behaviour:
- Reset: state=IDLE; all outputs 0; round-robin pointer last=NREQ-1, so requester 0 wins first. All outputs are registered.
- Arbitration, combinational pick in IDLE or on ACCESS completion:
  - Winner = first set bit of req_valid_i scanning last+1, last+2, … modulo NREQ.
  - On grant: latch addr, wdata, write, id; set last=id.
- IDLE: when any req_valid_i is set, grant and go to SETUP. Otherwise PSEL_o=0 and PENABLE_o=0.
- SETUP (exactly 1 cycle):
  - PSEL_o=1, PENABLE_o=0, PADDR/PWDATA/PWRITE = latched values.
  - req_ready_o[id]=1 this cycle only.
  - Next state ACCESS.
- Requester rule: drop req_valid_i at the edge after req_ready_o. It may reassert the next cycle for a new transfer.
- ACCESS:
  - PSEL_o=1, PENABLE_o=1; PADDR/PWDATA/PWRITE stable.
  - Timeout counter starts at 1 on ACCESS entry and increments while PREADY_i=0.
  - PREADY_i=1: on that edge, rsp_valid_o[id]=1 for the next cycle and rsp_err_o=PSLVERR_i. rsp_rdata_o=PRDATA_i for reads, 0 for writes.
    - Then go to SETUP directly with a new grant if any req_valid_i is set (back-to-back, PSEL_o stays 1, PENABLE_o drops to 0). Otherwise go to IDLE.
  - Counter reaches TIMEOUT with PREADY_i=0: abort. rsp_valid_o[id]=1, rsp_err_o=1, rsp_rdata_o=0; go to IDLE (PSEL_o=0). No back-to-back after an abort.
- Latency:
  - Idle request to PSEL_o: 1 cycle.
  - Zero-wait transfer: SETUP+ACCESS = 2 cycles.
  - rsp_valid_o appears 1 cycle after the PREADY_i edge.
- Only one transfer is outstanding. Simultaneous requests are serialised in round-robin order.
- A request from the just-served requester ranks last while others are pending.
- PREADY_i, PRDATA_i and PSLVERR_i are ignored outside ACCESS.
- Reset asserted mid-transfer: all outputs are forced to reset values immediately. The transfer is dropped with no rsp_valid_o, and the pointer returns to NREQ-1.
- rsp_valid_o and req_ready_o may be high in the same cycle for different ids (back-to-back case).

Decomposition:
- apb_pkg: typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS}; default AW/DW localparams.
- Sub-module apb_rr_arbiter: combinational round-robin pick.
  - Inputs: req mask, last pointer.
  - Outputs: grant_valid, grant_id.
  - The pointer register stays in the parent.

Test Plan:
- Reset, then req_valid_i=4'b0001 for a read at 8'h10 with PREADY_i=1 and PRDATA_i=8'hA5 → PSEL_o 1 cycle after the request, PENABLE_o the next cycle, rsp_valid_o=4'b0001, rsp_rdata_o=8'hA5, rsp_err_o=0; total 3 cycles.
- Write 8'h3C to 8'h20 from requester 2 with PREADY_i low for 3 ACCESS cycles → PADDR_o/PWDATA_o/PWRITE_o=1 stable for all 4 ACCESS cycles; rsp_valid_o=4'b0100, rsp_rdata_o=0.
- All four requesters valid simultaneously, always re-requesting, PREADY_i=1 → grant order 0,1,2,3,0; back-to-back with PSEL_o continuously 1 and PENABLE_o toggling every cycle.
- PREADY_i held 0 with TIMEOUT=16 → abort after 16 ACCESS cycles; rsp_err_o=1, rsp_rdata_o=0, PSEL_o=0 next cycle.
- PSLVERR_i=1 with PREADY_i=1 on a read → rsp_err_o=1 with the matching rsp_valid_o bit.
- PRESET asserted during ACCESS → PSEL_o and PENABLE_o are 0 immediately and no rsp_valid_o. After release, a pending requester 3 is granted in preference order 0,1,2,3.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and default bus widths for the APB master arbiter.
//   apb_state_e : IDLE / SETUP / ACCESS phases of the APB master
//   DEF_AW/DEF_DW : default address and data widths
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin pick among NREQ requesters.
//   req_i         : request mask
//   last_i        : id of the most recently granted requester
//   grant_valid_o : at least one request is pending
//   grant_id_o    : first set bit of req_i scanning last_i+1, last_i+2, ... modulo NREQ
module apb_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            grant_valid_o,
    output logic [IDW-1:0]  grant_id_o
);

    int             pos;
    logic [IDW-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after last_i is the final (winning) assignment.
    always_comb begin
        grant_id_o = '0;
        pos        = 0;
        idx        = '0;
        for (int i = NREQ; i >= 1; i--) begin
            pos = (int'(last_i) + i) % NREQ;
            idx = IDW'(pos);
            grant_id_o = req_i[idx] ? idx : grant_id_o;
        end
    end

    assign grant_valid_o = |req_i;

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NREQ requesters with
// round-robin arbitration and a PREADY timeout.
//   PCLK, PRESET             : clock, asynchronous active-high reset
//   req_valid_i/write/addr/wdata : per-requester command (flattened buses)
//   req_ready_o              : one-hot pulse in SETUP, command accepted
//   rsp_valid_o/rdata/err    : one-hot pulse with read data and error status
//   PADDR_o..PENABLE_o       : APB master outputs (all registered)
//   PRDATA_i/PREADY_i/PSLVERR_i : APB slave response, sampled only in ACCESS
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ-1:0]    req_write_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]      rsp_rdata_o,
    output logic               rsp_err_o,
    output logic [AW-1:0]      PADDR_o,
    output logic [DW-1:0]      PWDATA_o,
    output logic               PWRITE_o,
    output logic               PSEL_o,
    output logic               PENABLE_o,
    input  logic [DW-1:0]      PRDATA_i,
    input  logic               PREADY_i,
    input  logic               PSLVERR_i
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    apb_state_e      state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            write_q, write_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_write;
    logic            expired;
    logic            done;
    logic            take;

    apb_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i         (req_valid_i),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // last_q doubles as the id of the transfer in flight: it is set on grant.
    assign expired = (cnt_q == CW'(TIMEOUT)) && !PREADY_i;
    assign done    = (state_q == ACCESS) && (PREADY_i || expired);
    // A new grant is taken from IDLE or on a normal completion; never after an abort.
    assign take    = grant_valid && ((state_q == IDLE) || (state_q == ACCESS && PREADY_i));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_valid ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = PREADY_i ? (grant_valid ? SETUP : IDLE) : (expired ? IDLE : ACCESS);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_addr  = req_addr_i[i*AW +: AW];
                sel_wdata = req_wdata_i[i*DW +: DW];
                sel_write = req_write_i[i];
            end
        end
        psel_d      = state_d != IDLE;
        penable_d   = state_d == ACCESS;
        addr_d      = take ? sel_addr : addr_q;
        wdata_d     = take ? sel_wdata : wdata_q;
        write_d     = take ? sel_write : write_q;
        last_d      = take ? grant_id : last_q;
        req_ready_d = take ? NREQ'(1) << grant_id : '0;
        // Response uses the outgoing id, even when a new grant happens on the same edge.
        rsp_valid_d = done ? NREQ'(1) << last_q : '0;
        rsp_err_d   = done && (!PREADY_i || PSLVERR_i);
        rsp_rdata_d = (done && PREADY_i && !write_q) ? PRDATA_i : '0;
        cnt_d       = (state_d == ACCESS) ? ((state_q == ACCESS) ? cnt_q + 1'b1 : CW'(1)) : '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_q      <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign PADDR_o     = addr_q;
    assign PWDATA_o    = wdata_q;
    assign PWRITE_o    = write_q;
    assign PSEL_o      = psel_q;
    assign PENABLE_o   = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized bench for apb_master_arbiter with a cycle-level protocol model.
module tb_apb_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TIMEOUT = 16;

    logic               PCLK = 1'b0;
    logic               PRESET = 1'b1;
    logic [NREQ-1:0]    req_valid_i = '0;
    logic [NREQ-1:0]    req_write_i = '0;
    logic [NREQ*AW-1:0] req_addr_i = '0;
    logic [NREQ*DW-1:0] req_wdata_i = '0;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [DW-1:0]      rsp_rdata_o;
    logic               rsp_err_o;
    logic [AW-1:0]      PADDR_o;
    logic [DW-1:0]      PWDATA_o;
    logic               PWRITE_o;
    logic               PSEL_o;
    logic               PENABLE_o;
    logic [DW-1:0]      PRDATA_i = '0;
    logic               PREADY_i = 1'b0;
    logic               PSLVERR_i = 1'b0;

    apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PWRITE_o(PWRITE_o),
        .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
        .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // requester side: current pending command of each requester
    logic [AW-1:0] t_addr [NREQ];
    logic [DW-1:0] t_wdata [NREQ];
    logic          t_write [NREQ];
    logic [NREQ-1:0] inj = '0;
    int rate = 0;

    // slave control: -1 means random
    int fixed_wait = -1;
    int slv_data = -1;
    int slv_err = -1;

    // reference model: phase 0 idle, 1 setup, 2 access (k = access cycle number)
    int ph, k, cid, last, w;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_write;
    logic [NREQ-1:0] exp_ready, exp_rsp_v;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;

    // observations
    int order[$];
    int pen_cnt = 0;
    logic [NREQ-1:0] l_v = '0;
    logic [DW-1:0]   l_d = '0;
    logic            l_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int from);
        for (int j = 1; j <= NREQ; j++)
            if (v[(from + j) % NREQ]) return (from + j) % NREQ;
        return -1;
    endfunction

    task automatic new_tx(input int i);
        t_addr[i]  = AW'($urandom);
        t_wdata[i] = DW'($urandom);
        t_write[i] = 1'($urandom);
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_addr_i[i*AW +: AW]  = t_addr[i];
            req_wdata_i[i*DW +: DW] = t_wdata[i];
            req_write_i[i]          = t_write[i];
        end
    endtask

    task automatic model_reset();
        ph = 0; k = 0; cid = 0; w = 0; last = NREQ - 1;
        m_addr = '0; m_wdata = '0; m_write = 1'b0;
        exp_ready = '0; exp_rsp_v = '0; exp_err = 1'b0; exp_rdata = '0;
    endtask

    task automatic check_cycle();
        check("req_ready", req_ready_o, exp_ready);
        check("rsp_valid", rsp_valid_o, exp_rsp_v);
        if (exp_rsp_v != 0) begin
            check("rsp_err", rsp_err_o, exp_err);
            check("rsp_rdata", rsp_rdata_o, exp_rdata);
        end
        check("psel", PSEL_o, ph != 0);
        check("penable", PENABLE_o, ph == 2);
        if (ph != 0) begin
            check("paddr", PADDR_o, m_addr);
            check("pwrite", PWRITE_o, m_write);
            if (m_write) check("pwdata", PWDATA_o, m_wdata);
        end
        for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) order.push_back(i);
        if (PENABLE_o) pen_cnt++;
        if (rsp_valid_o != 0) begin
            l_v = rsp_valid_o; l_d = rsp_rdata_o; l_e = rsp_err_o;
        end
    endtask

    // A granted requester drops valid at the edge after req_ready and may re-request later.
    task automatic update_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (ph == 1 && i == cid) begin
                req_valid_i[i] = 1'b0;
                new_tx(i);
            end else if (!req_valid_i[i] && $urandom_range(99) < rate) begin
                req_valid_i[i] = 1'b1;
            end
        end
        req_valid_i = req_valid_i | inj;
        inj = '0;
        pack();
    endtask

    // Drives the slave for the coming edge and advances the model across that edge.
    task automatic slave_model();
        logic arb;
        int p;
        arb = 1'b0;
        PRDATA_i  = (slv_data >= 0) ? DW'(slv_data) : DW'($urandom);
        PSLVERR_i = (slv_err >= 0) ? slv_err[0] : ($urandom_range(3) == 0);
        PREADY_i  = (ph == 2) ? (w < TIMEOUT && k == w + 1) : 1'($urandom);
        exp_ready = '0; exp_rsp_v = '0; exp_err = 1'b0; exp_rdata = '0;
        if (ph == 0) arb = 1'b1;
        else if (ph == 1) begin ph = 2; k = 1; end
        else if (PREADY_i) begin
            exp_rsp_v = NREQ'(1) << cid; exp_err = PSLVERR_i;
            exp_rdata = m_write ? '0 : PRDATA_i;
            ph = 0; arb = 1'b1;
        end else if (k == TIMEOUT) begin
            exp_rsp_v = NREQ'(1) << cid; exp_err = 1'b1; exp_rdata = '0;
            ph = 0;
        end else k++;
        p = rr_pick(req_valid_i, last);
        if (arb && p >= 0) begin
            cid = p; last = p;
            m_addr = t_addr[p]; m_wdata = t_wdata[p]; m_write = t_write[p];
            w = (fixed_wait >= 0) ? fixed_wait : (($urandom_range(9) == 0) ? TIMEOUT : int'($urandom_range(3)));
            ph = 1;
            exp_ready = NREQ'(1) << p;
        end
    endtask

    task automatic step();
        @(negedge PCLK);
        check_cycle();
        update_reqs();
        slave_model();
    endtask

    task automatic drain();
        rate = 0;
        fixed_wait = 0;
        for (int n = 0; n < 200 && (req_valid_i != 0 || ph != 0); n++) step();
        check("drain_idle", (req_valid_i == 0 && ph == 0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) new_tx(i);
        pack();
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_psel", PSEL_o, 0);
        check("rst_penable", PENABLE_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_paddr", PADDR_o, 0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // all requesters continuously requesting, zero-wait slave
        rate = 100; fixed_wait = 0; order.delete();
        repeat (12) step();
        for (int j = 0; j < 5; j++) check("rr_order", (j < order.size()) ? order[j] : -1, exp_ord[j]);
        drain();

        // single zero-wait read from requester 0
        t_addr[0] = 8'h10; t_write[0] = 1'b0; pack();
        slv_data = 8'hA5; slv_err = 0; pen_cnt = 0; inj = 4'b0001;
        repeat (6) step();
        check("rd_rsp_valid", l_v, 4'b0001);
        check("rd_rdata", l_d, 8'hA5);
        check("rd_err", l_e, 0);
        check("rd_access_cycles", pen_cnt, 1);
        drain();

        // write from requester 2 with three wait states
        t_addr[2] = 8'h20; t_wdata[2] = 8'h3C; t_write[2] = 1'b1; pack();
        slv_data = -1; fixed_wait = 3; pen_cnt = 0; inj = 4'b0100;
        repeat (10) step();
        check("wr_rsp_valid", l_v, 4'b0100);
        check("wr_rdata", l_d, 0);
        check("wr_access_cycles", pen_cnt, 4);
        drain();

        // PREADY never arrives: abort after TIMEOUT access cycles
        t_write[1] = 1'b0; pack();
        fixed_wait = TIMEOUT; pen_cnt = 0; inj = 4'b0010;
        repeat (22) step();
        check("to_rsp_valid", l_v, 4'b0010);
        check("to_err", l_e, 1);
        check("to_rdata", l_d, 0);
        check("to_access_cycles", pen_cnt, TIMEOUT);
        drain();

        // slave error on a read
        t_write[3] = 1'b0; pack();
        fixed_wait = 0; slv_err = 1; inj = 4'b1000;
        repeat (6) step();
        check("se_rsp_valid", l_v, 4'b1000);
        check("se_err", l_e, 1);
        drain();

        // random traffic
        rate = 30; fixed_wait = -1; slv_data = -1; slv_err = -1;
        repeat (3000) step();

        // reset in the middle of an ACCESS phase
        rate = 60;
        for (int n = 0; n < 200 && ph != 2; n++) step();
        check("reach_access", ph == 2, 1);
        @(negedge PCLK);
        check_cycle();
        PRESET = 1'b1;
        #1;
        check("mid_rst_psel", PSEL_o, 0);
        check("mid_rst_penable", PENABLE_o, 0);
        check("mid_rst_rsp_valid", rsp_valid_o, 0);
        @(posedge PCLK);
        #1;
        check("mid_rst_rsp_valid2", rsp_valid_o, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        rate = 0; fixed_wait = 0; slv_err = 0;
        new_tx(3);
        req_valid_i = 4'b1000;
        pack();
        slave_model();
        order.delete();
        repeat (6) step();
        check("post_rst_grant", (order.size() > 0) ? order[0] : -1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
